spi_reg_ctrl: RTL and testbench

Write-only SPI slave that configures the PWM peripheral's five control registers from an external host. SPI pins are sampled in the system clock domain through synchronizers and shifted into a 16-bit frame. A complete, valid frame commits one byte to the addressed register. It sits between the chip's dedicated input pins and the PWM peripheral's register inputs, alongside the PWM instance in the top level.

---
 rtl/spi_reg_pkg.sv | 22 ++
 rtl/spi_sync.sv | 35 +++
 rtl/spi_reg_ctrl.sv | 145 ++++++++++++++
 tb/tb_spi_reg_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_pkg.sv
// Shared constants and types for the SPI register-configuration slave.
// Field positions assume the 16-bit frame: R/W, 7-bit address, 8-bit data.
package spi_reg_pkg;

    localparam int unsigned FRAME_BITS = 32'd16;

    localparam int unsigned RW_BIT   = 32'd15;
    localparam int unsigned ADDR_MSB = 32'd14;
    localparam int unsigned ADDR_LSB = 32'd8;

    localparam int unsigned ADDR_EN_OUT_LO = 32'h00;
    localparam int unsigned ADDR_EN_OUT_HI = 32'h01;
    localparam int unsigned ADDR_EN_PWM_LO = 32'h02;
    localparam int unsigned ADDR_EN_PWM_HI = 32'h03;
    localparam int unsigned ADDR_DUTY      = 32'h04;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer for one asynchronous pin, followed by an edge-detect flop.
// The edge pulses are one clk wide and line up with the synchronized level.
module spi_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // synchronizer chain plus the previous-level flop used for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            prev_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~prev_q;
    assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/spi_reg_ctrl.sv
// Write-only SPI mode-0 slave: collects a frame while ncs is low and, on a
// well-formed write frame, commits its data byte to one of the PWM control registers.
module spi_reg_ctrl #(
    parameter int unsigned NUM_REGS   = 32'd5,
    parameter int unsigned FRAME_BITS = 32'd16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_pulse,
    output logic       frame_err
);

    import spi_reg_pkg::*;

    localparam int unsigned CNT_W = $clog2(FRAME_BITS + 32'd2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_BITS + 32'd1);

    logic sclk_rise_s;
    logic copi_lvl_s;
    logic ncs_rise_s;
    logic ncs_fall_s;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    logic [7:0]              regs_q [NUM_REGS];
    logic [7:0]              regs_d [NUM_REGS];
    logic                    wr_pulse_q, wr_pulse_d;
    logic                    frame_err_q, frame_err_d;

    logic [6:0]              frame_addr_s;
    logic                    frame_write_s;

    spi_sync #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .d_i(sclk),
        .level_o(), .rise_o(sclk_rise_s), .fall_o()
    );

    spi_sync #(.RST_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst(rst), .d_i(copi),
        .level_o(copi_lvl_s), .rise_o(), .fall_o()
    );

    spi_sync #(.RST_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst(rst), .d_i(ncs),
        .level_o(), .rise_o(ncs_rise_s), .fall_o(ncs_fall_s)
    );

    // copi and sclk share the same synchronizer depth, so copi is aligned with the sclk rise
    assign frame_addr_s  = shift_q[ADDR_MSB:ADDR_LSB];
    assign frame_write_s = shift_q[RW_BIT] && (32'(frame_addr_s) < NUM_REGS);

    // state, counter, shift register, register file and pulse flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            wr_pulse_q  <= 1'b0;
            frame_err_q <= 1'b0;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            wr_pulse_q  <= wr_pulse_d;
            frame_err_q <= frame_err_d;
            regs_q      <= regs_d;
        end
    end

    // next-state logic; an ncs rise outranks an sclk rise in the same cycle
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        regs_d      = regs_q;
        wr_pulse_d  = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (ncs_fall_s) begin
                    state_d = RECV;
                    cnt_d   = '0;
                    shift_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            RECV: begin
                if (ncs_rise_s) begin
                    state_d = IDLE;
                    if (cnt_q == CNT_FULL) begin
                        if (frame_write_s) begin
                            wr_pulse_d = 1'b1;
                            for (int i = 0; i < int'(NUM_REGS); i++) begin
                                if (frame_addr_s == 7'(i)) begin
                                    regs_d[i] = shift_q[7:0];
                                end else begin
                                    regs_d[i] = regs_q[i];
                                end
                            end
                        end else begin
                            wr_pulse_d = 1'b0;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else if (sclk_rise_s) begin
                    shift_d = {shift_q[FRAME_BITS-2:0], copi_lvl_s};
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        cnt_d = cnt_q;
                    end
                end else begin
                    state_d = RECV;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign en_reg_out_7_0  = regs_q[ADDR_EN_OUT_LO];
    assign en_reg_out_15_8 = regs_q[ADDR_EN_OUT_HI];
    assign en_reg_pwm_7_0  = regs_q[ADDR_EN_PWM_LO];
    assign en_reg_pwm_15_8 = regs_q[ADDR_EN_PWM_HI];
    assign pwm_duty_cycle  = regs_q[ADDR_DUTY];
    assign wr_pulse        = wr_pulse_q;
    assign frame_err       = frame_err_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: a frame-level model predicts registers and pulses,
// checked every clk, plus literal expectations after each scenario.
module tb_spi_reg_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk;
    logic       copi;
    logic       ncs;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic       wr_pulse;
    logic       frame_err;

    logic [7:0] exp_regs [128];
    logic       exp_wr;
    logic       exp_err;
    bit         checking = 1'b0;
    int         vectors = 0;
    int         miscompares = 0;
    int         wr_seen = 0;
    int         err_seen = 0;
    int         wr_base;
    int         err_base;

    spi_reg_ctrl #(.NUM_REGS(32'd5), .FRAME_BITS(32'd16)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs),
        .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle(pwm_duty_cycle), .wr_pulse(wr_pulse), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            if (miscompares <= 40)
                $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            if (miscompares <= 40)
                $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // per-cycle comparison against the model, plus pulse counting
    always @(negedge clk) begin
        if (checking) begin
            check8("en_reg_out_7_0",  en_reg_out_7_0,  exp_regs[7'h00]);
            check8("en_reg_out_15_8", en_reg_out_15_8, exp_regs[7'h01]);
            check8("en_reg_pwm_7_0",  en_reg_pwm_7_0,  exp_regs[7'h02]);
            check8("en_reg_pwm_15_8", en_reg_pwm_15_8, exp_regs[7'h03]);
            check8("pwm_duty_cycle",  pwm_duty_cycle,  exp_regs[7'h04]);
            check8("wr_pulse",  {7'd0, wr_pulse},  {7'd0, exp_wr});
            check8("frame_err", {7'd0, frame_err}, {7'd0, exp_err});
            if (wr_pulse === 1'b1) wr_seen++;
            if (frame_err === 1'b1) err_seen++;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic shift_bit(input logic b);
        copi = b;
        wait_clk(4);
        sclk = 1'b1;
        wait_clk(4);
        sclk = 1'b0;
    endtask

    // frame-level model: result appears on the 3rd clk edge after ncs rises, pulses last one clk
    task automatic model_commit(input logic [16:0] frame, input int nbits);
        logic [6:0] addr;
        addr = frame[14:8];
        repeat (3) @(posedge clk);
        #1;
        if (nbits != 16) begin
            exp_err = 1'b1;
        end else if (frame[15] && addr < 7'd5) begin
            exp_regs[addr] = frame[7:0];
            exp_wr = 1'b1;
        end
        @(posedge clk);
        #1;
        exp_wr  = 1'b0;
        exp_err = 1'b0;
        #1;
        wait_clk(2);
    endtask

    task automatic send(input logic [16:0] frame, input int nbits);
        logic [16:0] f;
        f = frame << (17 - nbits);
        ncs = 1'b0;
        wait_clk(4);
        for (int i = 0; i < nbits; i++) begin
            shift_bit(f[16]);
            f = f << 1;
        end
        wait_clk(4);
        ncs = 1'b1;
        model_commit(frame, nbits);
    endtask

    initial begin
        logic [16:0] f;
        rst  = 1'b1;
        ncs  = 1'b1;
        sclk = 1'b0;
        copi = 1'b0;
        exp_wr  = 1'b0;
        exp_err = 1'b0;
        for (int i = 0; i < 128; i++) exp_regs[i] = 8'h00;
        checking = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(4);

        check8("reset_out_lo", en_reg_out_7_0,  8'h00);
        check8("reset_out_hi", en_reg_out_15_8, 8'h00);
        check8("reset_pwm_lo", en_reg_pwm_7_0,  8'h00);
        check8("reset_pwm_hi", en_reg_pwm_15_8, 8'h00);
        check8("reset_duty",   pwm_duty_cycle,  8'h00);

        wr_base = wr_seen;
        send(17'h08455, 16);
        check8("duty_0x55", pwm_duty_cycle, 8'h55);
        check_int("wr_count_single", wr_seen - wr_base, 1);

        wr_base = wr_seen;
        send(17'h080F0, 16);
        send(17'h081A5, 16);
        send(17'h082FF, 16);
        send(17'h08301, 16);
        check8("out_lo_F0", en_reg_out_7_0,  8'hF0);
        check8("out_hi_A5", en_reg_out_15_8, 8'hA5);
        check8("pwm_lo_FF", en_reg_pwm_7_0,  8'hFF);
        check8("pwm_hi_01", en_reg_pwm_15_8, 8'h01);
        check8("duty_kept", pwm_duty_cycle,  8'h55);
        check_int("wr_count_b2b", wr_seen - wr_base, 4);

        wr_base  = wr_seen;
        err_base = err_seen;
        send(17'h00477, 16);
        send(17'h08977, 16);
        check8("read_ignored", pwm_duty_cycle, 8'h55);
        check_int("wr_count_ignored", wr_seen - wr_base, 0);
        check_int("err_count_ignored", err_seen - err_base, 0);

        err_base = err_seen;
        wr_base  = wr_seen;
        send(17'h04055, 15);
        send(17'h10022, 17);
        check8("short_long_out_lo", en_reg_out_7_0, 8'hF0);
        check_int("err_count_short_long", err_seen - err_base, 2);
        check_int("wr_count_short_long", wr_seen - wr_base, 0);

        wr_base = wr_seen;
        ncs = 1'b0;
        wait_clk(4);
        f = 17'h08433 << 1;
        for (int i = 0; i < 10; i++) begin
            shift_bit(f[16]);
            f = f << 1;
        end
        wait_clk(1);
        rst  = 1'b1;
        ncs  = 1'b1;
        sclk = 1'b0;
        copi = 1'b0;
        for (int i = 0; i < 128; i++) exp_regs[i] = 8'h00;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(4);
        check8("abort_duty", pwm_duty_cycle, 8'h00);
        check8("abort_out_lo", en_reg_out_7_0, 8'h00);
        check_int("wr_count_abort", wr_seen - wr_base, 0);
        send(17'h08433, 16);
        check8("after_reset_duty", pwm_duty_cycle, 8'h33);
        check8("after_reset_pwm_hi", en_reg_pwm_15_8, 8'h00);
        check_int("wr_count_after_reset", wr_seen - wr_base, 1);

        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
